// File: rtl/unidade_exibicao_sequencia_pkg.sv
// -----------------------------------------------------------------------------
// unidade_exibicao_sequencia_pkg
//
// Purpose:
//   Shared definitions for the sequence playback controller. The state
//   encodings live here so that the game control unit, the debug hex display
//   and this controller all decode db_estado the same way.
//
// Contents:
//   estado_t               - 3-bit playback state encoding
//   ESTADO_W               - width of the state / db_estado bus
//   TEMPO_ACESO_PADRAO     - default lit time per element (cycles)
//   TEMPO_APAGADO_PADRAO   - default dark gap after each element (cycles)
//   estado_ocupado()       - true for the states that make up a playback
// -----------------------------------------------------------------------------
package unidade_exibicao_sequencia_pkg;

  localparam int ESTADO_W = 3;

  localparam int TEMPO_ACESO_PADRAO   = 1000;
  localparam int TEMPO_APAGADO_PADRAO = 500;

  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  // FIM is deliberately excluded: the busy flag drops in the same cycle
  // that pronto rises, so the control unit sees a clean hand-off.
  function automatic logic estado_ocupado(input estado_t estado);
    return (estado == CARREGA) || (estado == ACESO) ||
           (estado == APAGADO) || (estado == PROXIMO);
  endfunction

endpackage

// File: rtl/unidade_exibicao_sequencia_temporizador_exibicao.sv
// -----------------------------------------------------------------------------
// temporizador_exibicao
//
// Purpose:
//   Interval timer for the playback controller. A CNT_W-bit up-counter that
//   is cleared by zera, advances by one when conta is high, and reports via
//   fim (combinational) that it has reached the last cycle of the interval
//   currently selected: TEMPO_ACESO-1 or TEMPO_APAGADO-1.
//
// Ports:
//   clock              in   system clock, rising edge
//   reset              in   asynchronous, active-high reset (count -> 0)
//   zera               in   synchronous clear, has priority over conta
//   conta              in   count enable
//   seleciona_apagado  in   0: compare against lit time, 1: against dark gap
//   fim                out  count equals the selected terminal value
// -----------------------------------------------------------------------------
module temporizador_exibicao
  import unidade_exibicao_sequencia_pkg::*;
#(
  parameter int CNT_W         = 12,
  parameter int TEMPO_ACESO   = TEMPO_ACESO_PADRAO,
  parameter int TEMPO_APAGADO = TEMPO_APAGADO_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  input  logic seleciona_apagado,
  output logic fim
);

  // Terminal values are one less than the interval length because the
  // count starts at zero on the first cycle of the interval.
  localparam logic [CNT_W-1:0] LIMITE_ACESO   = CNT_W'(TEMPO_ACESO - 1);
  localparam logic [CNT_W-1:0] LIMITE_APAGADO = CNT_W'(TEMPO_APAGADO - 1);

  logic [CNT_W-1:0] r_contagem;
  logic [CNT_W-1:0] w_limite;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_contagem <= '0;
    end else if (zera) begin
      r_contagem <= '0;
    end else if (conta) begin
      r_contagem <= r_contagem + CNT_W'(1);
    end
  end

  assign w_limite = seleciona_apagado ? LIMITE_APAGADO : LIMITE_ACESO;
  assign fim      = (r_contagem == w_limite);

endmodule

// File: rtl/unidade_exibicao_sequencia.sv
// -----------------------------------------------------------------------------
// unidade_exibicao_sequencia
//
// Purpose:
//   Plays back the stored game sequence on the LEDs. On iniciar the last
//   index (limite) is latched and the sequence RAM is walked from address 0
//   up to that index. Every element is shown for TEMPO_ACESO cycles and then
//   followed by TEMPO_APAGADO dark cycles. A one-cycle pronto pulse marks the
//   end of playback; cancelar aborts it at any point without a pronto pulse.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   iniciar       in   start request, only honoured while idle
//   cancelar      in   abort request, overrides every other transition
//   limite        in   index of the last element to show, latched on start
//   dado_memoria  in   sequence RAM read data (asynchronous read of endereco)
//   endereco      out  sequence RAM read address
//   leds          out  LED pattern, all zero while dark
//   ocupado       out  playback in progress
//   pronto        out  one-cycle end-of-playback pulse
//   db_estado     out  current state encoding, for debug displays
// -----------------------------------------------------------------------------
module unidade_exibicao_sequencia
  import unidade_exibicao_sequencia_pkg::*;
#(
  parameter int ADDR_W        = 4,
  parameter int DADO_W        = 4,
  parameter int CNT_W         = 12,
  parameter int TEMPO_ACESO   = TEMPO_ACESO_PADRAO,
  parameter int TEMPO_APAGADO = TEMPO_APAGADO_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                cancelar,
  input  logic [ADDR_W-1:0]   limite,
  input  logic [DADO_W-1:0]   dado_memoria,
  output logic [ADDR_W-1:0]   endereco,
  output logic [DADO_W-1:0]   leds,
  output logic                ocupado,
  output logic                pronto,
  output logic [ESTADO_W-1:0] db_estado
);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  estado_t           r_estado;
  estado_t           w_proximo_estado;

  logic [ADDR_W-1:0] r_endereco;
  logic [ADDR_W-1:0] r_limite;
  logic [DADO_W-1:0] r_dado;

  // Control strobes produced by the next-state logic
  logic w_carrega_limite;
  logic w_carrega_dado;
  logic w_incrementa;
  logic w_zera_tempo;
  logic w_conta_tempo;
  logic w_seleciona_apagado;
  logic w_fim_tempo;
  logic w_ultimo;
  logic w_cancela;

  // ---------------------------------------------------------------------------
  // Interval timer
  // ---------------------------------------------------------------------------
  temporizador_exibicao #(
    .CNT_W         (CNT_W),
    .TEMPO_ACESO   (TEMPO_ACESO),
    .TEMPO_APAGADO (TEMPO_APAGADO)
  ) u_temporizador (
    .clock             (clock),
    .reset             (reset),
    .zera              (w_zera_tempo),
    .conta             (w_conta_tempo),
    .seleciona_apagado (w_seleciona_apagado),
    .fim               (w_fim_tempo)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_proximo_estado;
    end
  end

  // The address is only ever compared for equality against the latched
  // limit, so it can never step past it and wrap around.
  assign w_ultimo  = (r_endereco == r_limite);

  // Cancelling while already idle is a no-op; elsewhere it wins outright.
  assign w_cancela = cancelar && (r_estado != OCIOSO);

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_proximo_estado    = r_estado;
    w_carrega_limite    = 1'b0;
    w_carrega_dado      = 1'b0;
    w_incrementa        = 1'b0;
    w_zera_tempo        = 1'b0;
    w_conta_tempo       = 1'b0;
    w_seleciona_apagado = (r_estado == APAGADO);

    case (r_estado)
      OCIOSO: begin
        if (iniciar) begin
          w_carrega_limite = 1'b1;
          w_proximo_estado = CARREGA;
        end
      end

      CARREGA: begin
        // The RAM read is asynchronous, so the word for the current address
        // is already valid here and can be captured directly.
        w_carrega_dado   = 1'b1;
        w_zera_tempo     = 1'b1;
        w_proximo_estado = ACESO;
      end

      ACESO: begin
        w_conta_tempo = 1'b1;
        if (w_fim_tempo) begin
          w_zera_tempo     = 1'b1;
          w_proximo_estado = APAGADO;
        end
      end

      APAGADO: begin
        w_conta_tempo = 1'b1;
        if (w_fim_tempo) begin
          w_zera_tempo     = 1'b1;
          w_proximo_estado = w_ultimo ? FIM : PROXIMO;
        end
      end

      PROXIMO: begin
        w_incrementa     = 1'b1;
        w_proximo_estado = CARREGA;
      end

      FIM: begin
        // iniciar is deliberately not looked at here: a start request seen
        // during the pronto cycle must not chain into a new playback.
        w_proximo_estado = OCIOSO;
      end

      default: begin
        w_proximo_estado = OCIOSO;
      end
    endcase

    if (w_cancela) begin
      w_proximo_estado = OCIOSO;
      w_carrega_dado   = 1'b0;
      w_incrementa     = 1'b0;
      w_conta_tempo    = 1'b0;
      w_zera_tempo     = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_endereco <= '0;
      r_limite   <= '0;
    end else if (w_carrega_limite) begin
      r_limite   <= limite;
      r_endereco <= '0;
    end else if (w_incrementa) begin
      r_endereco <= r_endereco + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dado <= '0;
    end else if (w_carrega_dado) begin
      r_dado <= dado_memoria;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    leds      = '0;
    ocupado   = 1'b0;
    pronto    = 1'b0;
    db_estado = r_estado;

    if (r_estado == ACESO) begin
      leds = r_dado;
    end
    ocupado = estado_ocupado(r_estado);
    pronto  = (r_estado == FIM);
  end

  // The address keeps its value after playback so the last index stays
  // visible to the datapath until the next start.
  assign endereco = r_endereco;

endmodule

// File: tb/tb_unidade_exibicao_sequencia.sv
module tb_unidade_exibicao_sequencia;

  localparam int TA  = 3;
  localparam int TP  = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       cancelar;
  logic [3:0] limite;
  logic [3:0] dado_memoria;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [2:0] db_estado;

  logic [3:0] ram [16];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign dado_memoria = ram[endereco];

  unidade_exibicao_sequencia #(
    .ADDR_W        (4),
    .DADO_W        (4),
    .CNT_W         (12),
    .TEMPO_ACESO   (TA),
    .TEMPO_APAGADO (TP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .cancelar     (cancelar),
    .limite       (limite),
    .dado_memoria (dado_memoria),
    .endereco     (endereco),
    .leds         (leds),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Drives iniciar for one edge; returns at the first observation after it.
  task automatic start(input logic [3:0] lim);
    limite  = lim;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: expected per-cycle outputs of a whole playback, built
  // directly from the timing rules (load, lit, dark, advance, done).
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0] leds;
    logic       ocup;
    logic       pronto;
    logic [3:0] addr;
    logic [2:0] est;
  } amostra_t;

  amostra_t esperado[$];

  task automatic monta(input int lim);
    esperado.delete();
    for (int k = 0; k <= lim; k++) begin
      esperado.push_back('{4'd0, 1'b1, 1'b0, 4'(k), 3'd1});
      for (int c = 0; c < TA; c++) esperado.push_back('{ram[k], 1'b1, 1'b0, 4'(k), 3'd2});
      for (int c = 0; c < TP; c++) esperado.push_back('{4'd0, 1'b1, 1'b0, 4'(k), 3'd3});
      if (k < lim) esperado.push_back('{4'd0, 1'b1, 1'b0, 4'(k), 3'd4});
    end
    esperado.push_back('{4'd0, 1'b0, 1'b1, 4'(lim), 3'd5});
    for (int c = 0; c < 2; c++) esperado.push_back('{4'd0, 1'b0, 1'b0, 4'(lim), 3'd0});
  endtask

  // ---------------------------------------------------------------------------
  // Observation window: summarises what the LEDs and handshake did.
  // ---------------------------------------------------------------------------
  int         obs_pronto_j, obs_pronto_cnt, obs_lit, obs_run_min, obs_run_max;
  int         obs_dark, obs_ocup_antes, obs_ocup_pronto, obs_ocup_apos;
  logic [15:0] obs_seq;
  logic [3:0]  obs_end_fim;

  task automatic observa(input int janela, input int ini_j1, input int ini_j2);
    int run_cur = 0;
    int first_lit = -1;
    int last_lit = -1;
    logic [3:0] prev_leds = 4'd0;
    logic prev_ocup = 1'b0;
    obs_pronto_j = -1; obs_pronto_cnt = 0; obs_lit = 0;
    obs_run_min = 9999; obs_run_max = 0; obs_dark = 0;
    obs_ocup_antes = -1; obs_ocup_pronto = -1; obs_ocup_apos = 0;
    obs_seq = 16'h0; obs_end_fim = 4'hx;
    for (int j = 0; j < janela; j++) begin
      if (pronto) begin
        obs_pronto_cnt++;
        if (obs_pronto_j < 0) begin
          obs_pronto_j    = j;
          obs_end_fim     = endereco;
          obs_ocup_antes  = int'(prev_ocup);
          obs_ocup_pronto = int'(ocupado);
        end
      end else if (obs_pronto_j >= 0 && ocupado) begin
        obs_ocup_apos++;
      end
      if (leds != 4'd0) begin
        obs_lit++;
        run_cur++;
        if (first_lit < 0) first_lit = j;
        last_lit = j;
        if (prev_leds == 4'd0) obs_seq = {obs_seq[11:0], leds};
      end else if (run_cur > 0) begin
        if (run_cur < obs_run_min) obs_run_min = run_cur;
        if (run_cur > obs_run_max) obs_run_max = run_cur;
        run_cur = 0;
      end
      prev_leds = leds;
      prev_ocup = ocupado;
      iniciar = (j == ini_j1) || (j == ini_j2);
      if (ini_j1 >= 0 && j >= ini_j1) limite = 4'd0;
      step();
    end
    iniciar = 1'b0;
    if (first_lit >= 0) obs_dark = (last_lit - first_lit + 1) - obs_lit;
  endtask

  typedef struct {
    logic [3:0]  lim;
    int          pronto_j;
    int          lit;
    int          dark;
    logic [15:0] seq;
  } vetor_t;

  vetor_t tabela[4];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tabela[0] = '{4'd2, 20,  9,  8, 16'h0124};
    tabela[1] = '{4'd0,  6,  3,  0, 16'h0001};
    tabela[2] = '{4'd3, 27, 12, 12, 16'h1248};
    tabela[3] = '{4'd1, 13,  6,  4, 16'h0012};

    for (int a = 0; a < 16; a++) ram[a] = 4'd0;
    ram[0] = 4'd1; ram[1] = 4'd2; ram[2] = 4'd4; ram[3] = 4'd8;

    reset = 1'b1; iniciar = 1'b0; cancelar = 1'b0; limite = 4'd0;
    repeat (3) step();
    reset = 1'b0;

    // ---- idle after reset ----------------------------------------------------
    for (int j = 0; j < 10; j++) begin
      step();
      chk($sformatf("reset_idle_j%0d", j), {leds, ocupado, pronto, db_estado, endereco}, 32'h0);
    end
    $display("reset idle: 10 cycles observed");

    // ---- table-driven playbacks ---------------------------------------------
    for (int i = 0; i < 4; i++) begin
      start(tabela[i].lim);
      observa(tabela[i].pronto_j + 5, -1, -1);
      chk($sformatf("t%0d_pronto_j", i),    obs_pronto_j,   tabela[i].pronto_j);
      chk($sformatf("t%0d_pronto_cnt", i),  obs_pronto_cnt, 1);
      chk($sformatf("t%0d_lit", i),         obs_lit,        tabela[i].lit);
      chk($sformatf("t%0d_run_min", i),     obs_run_min,    TA);
      chk($sformatf("t%0d_run_max", i),     obs_run_max,    TA);
      chk($sformatf("t%0d_dark", i),        obs_dark,       tabela[i].dark);
      chk($sformatf("t%0d_seq", i),         obs_seq,        tabela[i].seq);
      chk($sformatf("t%0d_end_fim", i),     obs_end_fim,    tabela[i].lim);
      chk($sformatf("t%0d_ocup_antes", i),  obs_ocup_antes, 1);
      chk($sformatf("t%0d_ocup_pronto", i), obs_ocup_pronto, 0);
      chk($sformatf("t%0d_ocup_apos", i),   obs_ocup_apos,  0);
      $display("playback limite=%0d: pronto at %0d, seq %h", tabela[i].lim, obs_pronto_j, obs_seq);
    end

    // ---- limite change + iniciar during playback and in the pronto cycle ----
    start(4'd3);
    observa(32, 5, 27);
    chk("repulse_seq",        obs_seq,        16'h1248);
    chk("repulse_pronto_cnt", obs_pronto_cnt, 1);
    chk("repulse_pronto_j",   obs_pronto_j,   27);
    chk("repulse_ocup_apos",  obs_ocup_apos,  0);
    $display("ignored inputs: seq %h, pronto pulses %0d", obs_seq, obs_pronto_cnt);

    // ---- cancel while the second element is lit ------------------------------
    start(4'd3);
    n = 0;
    while (leds != 4'd2 && n < 40) begin step(); n++; end
    chk("cancel_reach_leds2", leds, 4'd2);
    cancelar = 1'b1; iniciar = 1'b1;
    step();
    cancelar = 1'b0; iniciar = 1'b0;
    chk("cancel_estado",   db_estado, 3'd0);
    chk("cancel_leds",     leds,      4'd0);
    chk("cancel_ocupado",  ocupado,   1'b0);
    chk("cancel_endereco", endereco,  4'd1);
    observa(30, -1, -1);
    chk("cancel_no_pronto", obs_pronto_cnt, 0);
    chk("cancel_no_leds",   obs_lit,        0);
    $display("cancel: idle, no pronto in 30 cycles");

    // ---- asynchronous reset mid-ACESO ----------------------------------------
    start(4'd3);
    n = 0;
    while (leds != 4'd2 && n < 40) begin step(); n++; end
    chk("areset_reach_leds2", leds, 4'd2);
    #2 reset = 1'b1;
    #1;
    chk("areset_outputs", {leds, ocupado, pronto, db_estado, endereco}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    step();
    start(4'd3);
    chk("areset_restart_end", endereco,  4'd0);
    chk("areset_restart_est", db_estado, 3'd1);
    step();
    chk("areset_restart_led", leds, 4'd1);
    repeat (30) step();
    $display("async reset: restart from address 0");

    // ---- randomized playbacks against the reference model --------------------
    for (int it = 0; it < 8; it++) begin
      int lim;
      int fim_j;
      int err0;
      lim = $urandom_range(0, 15);
      for (int a = 0; a < 16; a++) ram[a] = 4'($urandom_range(0, 15));
      monta(lim);
      fim_j = esperado.size() - 3;
      err0 = errors;
      start(4'(lim));
      for (int j = 0; j < esperado.size(); j++) begin
        chk($sformatf("rand%0d_j%0d", it, j),
            {leds, ocupado, pronto, endereco, db_estado}, 32'(esperado[j]));
        if (j <= fim_j) begin
          iniciar = 1'($urandom_range(0, 1));
          limite  = 4'($urandom_range(0, 15));
        end else begin
          iniciar = 1'b0;
        end
        step();
      end
      iniciar = 1'b0;
      $display("random %0d: limite=%0d, %0d cycles, %0d new errors", it, lim, esperado.size(), errors - err0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_exibicao_sequencia.md
Name: unidade_exibicao_sequencia

Overview:
- Controller that plays back the stored game sequence on the LEDs.
- Steps the sequence-memory address from 0 up to a latched limit and shows each stored value for a fixed on-time, followed by a fixed dark gap.
- Signals completion with a one-cycle pronto pulse.
- Sits between the game control unit, which pulses iniciar and waits for pronto, and the datapath sequence RAM and LED mux.

Parameters:
- ADDR_W, 4, width of the sequence address and of limite
- DADO_W, 4, width of the memory word and of the LED bus
- CNT_W, 12, width of the internal interval timer; must be at least clog2 of the larger of TEMPO_ACESO and TEMPO_APAGADO
- TEMPO_ACESO, 1000, cycles each element is lit; must be at least 1
- TEMPO_APAGADO, 500, cycles of dark gap after each element; must be at least 1

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- iniciar  in  1  start request, sampled only in OCIOSO
- cancelar  in  1  abort request, highest priority
- limite  in  ADDR_W  index of the last element to show, latched on start
- dado_memoria  in  DADO_W  sequence RAM read data; asynchronous read of endereco
- endereco  out  ADDR_W  sequence RAM read address
- leds  out  DADO_W  LED pattern, all zero when dark
- ocupado  out  1  playback in progress
- pronto  out  1  one-cycle end-of-playback pulse
- db_estado  out  3  current state encoding, for debug

Behaviour:
- Reset (async, any time, including mid-playback):
  - state OCIOSO, endereco 0, limite_reg 0, dado_reg 0, timer 0
  - leds 0, ocupado 0, pronto 0
- States and encodings:
  - OCIOSO 0, CARREGA 1, ACESO 2, APAGADO 3, PROXIMO 4, FIM 5
  - unused encodings go to OCIOSO
- OCIOSO:
  - iniciar=1: limite_reg <= limite, endereco <= 0, go to CARREGA
  - otherwise stay
- CARREGA (1 cycle): dado_reg <= dado_memoria, timer <= 0, go to ACESO.
- ACESO: timer increments. When timer == TEMPO_ACESO-1: timer <= 0, go to APAGADO.
- APAGADO: timer increments. When timer == TEMPO_APAGADO-1:
  - if endereco == limite_reg, go to FIM
  - else go to PROXIMO
- PROXIMO (1 cycle): endereco <= endereco+1, go to CARREGA.
- FIM (1 cycle): go to OCIOSO.
- Outputs are Moore, decoded from the state:
  - leds = dado_reg in ACESO, else 0
  - ocupado = 1 in CARREGA, ACESO, APAGADO, PROXIMO
  - pronto = 1 only in FIM
  - endereco holds its value outside PROXIMO and OCIOSO start; it stays at the last index after completion until the next start
- Timing:
  - Each element is lit exactly TEMPO_ACESO cycles.
  - The dark interval is TEMPO_APAGADO+2 cycles between elements, and TEMPO_APAGADO cycles after the last one.
  - With N = limite+1 and iniciar sampled at edge E0, FIM is entered at edge E0 + N*(TEMPO_ACESO+TEMPO_APAGADO+2) - 1.
- cancelar=1 in any state other than OCIOSO:
  - next state OCIOSO, timer <= 0
  - leds 0 from the next cycle, no pronto pulse
  - cancelar overrides every other transition, including iniciar in the same cycle
- Ignored inputs:
  - iniciar outside OCIOSO, including during FIM; no restart
  - changes to limite after the start edge, since the value is latched
- limite=0: exactly one element (address 0) is shown.
- limite = 2^ADDR_W-1: all addresses are shown. endereco never increments past limite_reg, so there is no wrap-around.

Decomposition:
- Shared package: state encodings (the six 3-bit constants) plus the default TEMPO constants, so the game control unit and debug hex display decode db_estado identically.
- One sub-module, temporizador_exibicao: CNT_W-bit counter with inputs zera and conta, and a combinational fim output for a compare against a selectable limit (TEMPO_ACESO-1 or TEMPO_APAGADO-1).

Test Plan (bench uses TEMPO_ACESO=3, TEMPO_APAGADO=2; RAM preloaded with 1,2,4,8):
- Reset release, no iniciar for 10 cycles -> leds=0, ocupado=0, pronto=0, db_estado=0 throughout.
- limite=2, iniciar pulse at E0 -> leds shows 1, 2, 4, each for exactly 3 cycles, separated by 4 dark cycles; endereco 0→1→2; pronto high for one cycle entered at E0+20; ocupado falls with it.
- limite=0 -> single element 1 lit 3 cycles; pronto entered at E0+6.
- limite=3; limite changed to 0 and iniciar re-pulsed during playback -> all four values 1, 2, 4, 8 shown; exactly one pronto pulse.
- cancelar asserted while leds=2 -> next cycle db_estado=0, leds=0, ocupado=0; no pronto in the following 30 cycles.
- reset asserted mid-ACESO, asynchronously between edges -> outputs at reset values immediately; a new iniciar after release restarts from endereco 0.
